dup_word_source: RTL and testbench

Stimulus source for the consecutive-duplicate tally block. Emits a series of 8-bit words, one per accepted transfer, with duplicates (a word equal to the one before it) inserted at a programmed period. It also maintains the tally a correct checker must reach. It sits upstream of the checker: `data_out` drives the checker's data input and `valid & ready` drives the checker's enable.

---
 rtl/dup_word_source_pkg.sv | 18 +
 rtl/dup_word_if.sv | 23 ++
 rtl/dup_word_source_lfsr8.sv | 30 +++
 rtl/dup_word_source.sv | 159 +++++++++++++++
 tb/tb_dup_word_source.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dup_word_source_pkg.sv
// Shared types and LFSR model for the duplicate-word source.
// The checker bench reuses lfsr_next to rebuild the word sequence.
package dup_word_source_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // x^8+x^6+x^5+x^4+1 as a mask over q[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dup_word_if.sv
// Valid/ready word stream from the source to the tally checker.
// The master drives valid/data_out, the slave drives ready.
interface dup_word_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data_out;

  modport master (
    output valid,
    output data_out,
    input  ready
  );

  modport slave (
    input  valid,
    input  data_out,
    output ready
  );

endinterface

// File: rtl/dup_word_source_lfsr8.sv
// 8-bit Fibonacci LFSR, advanced one step when step is high.
// Never reaches zero from a nonzero seed.
module lfsr8
  import dup_word_source_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // next state: shift in the tap parity on step
  always_comb begin
    q_d = step ? lfsr_next(q_q) : q_q;
  end

  // state register, reloads the seed on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dup_word_source.sv
// Word series source with periodic forced duplicates and the
// duplicate tally a correct downstream checker must reach.
module dup_word_source
  import dup_word_source_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         CNT_W = 10,
  parameter logic [7:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic [3:0]       rep_every,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_count,
  dup_word_if.master       bus
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       phase_q, phase_d;

  logic             xfer;
  logic             gen;
  logic             dup;
  logic             step;
  logic [3:0]       rep_sel;
  logic [3:0]       ph_sel;
  logic [WIDTH-1:0] dup_src;
  logic [7:0]       lfsr_q;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .q     (lfsr_q)
  );

  // FSM, word generation and tally next-state
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    data_d  = data_q;
    last_d  = last_q;
    exp_d   = exp_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    phase_d = phase_q;
    gen     = 1'b0;
    rep_sel = rep_q;
    ph_sel  = phase_q;
    dup_src = data_q;
    xfer    = (state_q == S_RUN) && valid_q && bus.ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = length;
          rep_d = rep_every;
          idx_d = '0;
          if (length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            gen     = 1'b1;
            rep_sel = rep_every;
            ph_sel  = rep_every;
            dup_src = last_q;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          last_d = data_q;
          if (data_q == last_q) exp_d = exp_q + CNT_W'(1);
          if (idx_q == len_q - CNT_W'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            gen   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // the phase counter hits 1 on every rep_sel-th word
    dup  = (rep_sel != 4'd0) && (ph_sel == 4'd1);
    step = gen && !dup;
    if (gen) begin
      data_d = dup ? dup_src : WIDTH'(lfsr_next(lfsr_q));
      if (rep_sel != 4'd0) phase_d = dup ? rep_sel : ph_sel - 4'd1;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= '0;
      exp_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      last_q  <= last_d;
      exp_q   <= exp_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      phase_q <= phase_d;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign exp_count    = exp_q;

endmodule

// File: tb/tb_dup_word_source.sv
// Bench for dup_word_source: series table plus scoreboard of
// expected words, and hand sequences for busy-start and reset.
module tb_dup_word_source;

  typedef struct {
    int len;
    int k;
    int stall_at;
    int stall_n;
    int exp;
    int pre_rst;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] length;
  logic [3:0] rep_every;
  logic       busy;
  logic       done;
  logic [9:0] exp_count;

  int tests = 0;
  int fails = 0;
  int nx = 0;
  int done_cnt = 0;

  logic [7:0] sb[$];
  logic [7:0] m_last;
  logic [7:0] m_lfsr;
  logic [7:0] exp_w;

  dup_word_if #(.WIDTH(8)) bus ();

  dup_word_source #(
    .WIDTH (8),
    .CNT_W (10),
    .SEED  (8'h01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .rep_every (rep_every),
    .busy      (busy),
    .done      (done),
    .exp_count (exp_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_init();
    m_last = 8'h00;
    m_lfsr = 8'h01;
    sb.delete();
  endtask

  task automatic model_push(input int len, input int k);
    logic [7:0] w;
    for (int i = 0; i < len; i++) begin
      if (k != 0 && ((i + 1) % k) == 0) begin
        w = m_last;
      end else begin
        m_lfsr = nxt(m_lfsr);
        w = m_lfsr;
      end
      sb.push_back(w);
      m_last = w;
    end
  endtask

  // transfer monitor: pop and compare each accepted word
  always @(negedge clk) begin
    if (reset && bus.valid && bus.ready) begin
      nx++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word: unexpected word %0d", bus.data_out);
      end else begin
        exp_w = sb.pop_front();
        chk("word", bus.data_out, exp_w);
      end
    end
    if (reset && done) done_cnt++;
  end

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  task automatic wait_done(input int d0, input int budget,
                           input vec_t v);
    int   cyc;
    bit   stalled;
    logic [7:0] held;
    cyc = 0;
    stalled = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (!stalled && v.stall_n != 0 && nx == v.stall_at) begin
        bus.ready = 1'b0;
        held = bus.data_out;
        for (int s = 0; s < v.stall_n; s++) begin
          @(negedge clk);
          chk("stall_valid", bus.valid, 1);
          chk("stall_data", bus.data_out, held);
          @(posedge clk); #1;
        end
        bus.ready = 1'b1;
        stalled = 1;
      end
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done");
    end
  endtask

  task automatic run_series(input vec_t v);
    int nx0;
    int d0;
    if (v.pre_rst != 0) do_reset();
    nx = 0;
    nx0 = nx;
    d0 = done_cnt;
    model_push(v.len, v.k);
    start = 1'b1;
    length = 10'(v.len);
    rep_every = 4'(v.k);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (v.len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_valid", bus.valid, 0);
    end else begin
      chk("start_valid", bus.valid, 1);
      chk("start_busy", busy, 1);
    end
    wait_done(d0, 2 * v.len + 40, v);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("end_busy", busy, 0);
    chk("end_valid", bus.valid, 0);
    chk("word_count", nx - nx0, v.len);
    chk("sb_left", sb.size(), 0);
    chk("exp_count", exp_count, v.exp);
  endtask

  vec_t vecs[8];
  vec_t nv;

  initial begin
    int nx0;
    int d0;
    int cyc;

    vecs = '{
      '{5,    0, 0, 0, 0,    0},
      '{3,    1, 0, 0, 3,    1},
      '{2,    1, 0, 0, 5,    0},
      '{6,    2, 0, 0, 8,    0},
      '{8,    3, 3, 4, 10,   0},
      '{0,    0, 0, 0, 10,   0},
      '{1013, 1, 0, 0, 1023, 0},
      '{1,    1, 0, 0, 0,    0}
    };
    nv = '{0, 0, 0, 0, 0, 0};

    reset = 1'b0;
    start = 1'b0;
    length = '0;
    rep_every = '0;
    bus.ready = 1'b1;
    model_init();
    #12;
    chk("rst_valid", bus.valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_exp", exp_count, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_series(vecs[i]);

    // start while busy must not restart or resize the series
    nx = 0;
    nx0 = nx;
    d0 = done_cnt;
    model_push(4, 0);
    start = 1'b1;
    length = 10'd4;
    rep_every = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (nx - nx0 < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b1;
    length = 10'd9;
    rep_every = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 50, nv);
    @(negedge clk);
    chk("busy_start_words", nx - nx0, 4);
    chk("busy_start_sb", sb.size(), 0);
    chk("busy_start_exp", exp_count, 0);

    // reset mid-series aborts asynchronously
    nx = 0;
    nx0 = nx;
    model_push(10, 0);
    start = 1'b1;
    length = 10'd10;
    rep_every = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (nx - nx0 < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", bus.valid, 0);
    chk("arst_data", bus.data_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_exp", exp_count, 0);
    model_init();
    @(negedge clk);
    reset = 1'b1;

    nv = '{2, 0, 0, 0, 0, 0};
    run_series(nv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
